// File: rtl/pll_lock_supervisor.sv
// rPLL bring-up and supervision: PLL reset pulse, lock qualification with retries,
// in-service lock-loss handling and reset-guarded phase/duty reconfiguration.
module pll_lock_supervisor #(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ready,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_APPLY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             lock_meta_r;
  logic             lock_s_r;

  assign cfg_ready = (state_r == ST_RUN) && lock_s_r;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_s_r    <= lock_meta_r;
    end
  end

  // Supervisor state machine with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_RST_PLL;
      cnt_r           <= '0;
      pll_reset       <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= 2'd0;
      lock_loss_count <= 8'd0;
      pll_psda        <= 4'b0000;
      pll_dutyda      <= 4'b1000;
    end else begin
      case (state_r)
        ST_RST_PLL: begin
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
          if (cnt_r == PULSE_LAST) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_r) begin
            state_r <= ST_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            cnt_r     <= '0;
            pll_reset <= 1'b1;
            if (retry_count == RETRY_LIMIT) begin
              state_r <= ST_FAULT;
              fault   <= 1'b1;
            end else begin
              state_r     <= ST_RST_PLL;
              retry_count <= retry_count + 2'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s_r) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r     <= ST_RUN;
            cnt_r       <= '0;
            sys_reset   <= 1'b0;
            ready       <= 1'b1;
            retry_count <= 2'd0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          // Lock loss is checked first so it always beats a same-cycle request.
          if (!lock_s_r) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end else begin
              lock_loss_count <= lock_loss_count;
            end
          end else if (cfg_valid && cfg_ready) begin
            state_r    <= ST_APPLY;
            cnt_r      <= '0;
            pll_psda   <= cfg_psda;
            pll_dutyda <= cfg_dutyda;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
          end else begin
            cnt_r <= '0;
          end
        end
        ST_APPLY: begin
          // One extra cycle lets the new codes reach the rPLL before the window counts.
          if (!lock_s_r) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == SETTLE_LAST) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_FAULT: begin
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state_r   <= ST_RST_PLL;
          cnt_r     <= '0;
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule
